// File: rtl/alu_seq_pkg.sv
// Shared constants for the sequential add/subtract arbiter: default width,
// opcode encodings and FSM state encoding.
package alu_seq_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_RSB  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu_addsub_core.sv
// Combinational ADD/SUB/RSB/PASS datapath sharing one adder.
// {N,Z,C,V} output exists only when ALU_SEQ_FLAGS_EN is defined.
module alu_addsub_core
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
`ifdef ALU_SEQ_FLAGS_EN
    output logic [3:0]        flags,
`endif
    output logic [DATA_W-1:0] result
);

`ifdef ALU_SEQ_FLAGS_EN
    localparam int SUM_W = DATA_W + 1;
`else
    localparam int SUM_W = DATA_W;
`endif

    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] y_eff;
    logic              sub;
    logic [SUM_W-1:0]  sum;

    // Subtraction is x + ~y + 1; RSB just swaps which operand is x.
    always_comb begin
        x   = a;
        y   = b;
        sub = 1'b0;
        case (op)
            OP_SUB: sub = 1'b1;
            OP_RSB: begin
                x   = b;
                y   = a;
                sub = 1'b1;
            end
            default: ;
        endcase
        y_eff  = sub ? ~y : y;
        sum    = SUM_W'(x) + SUM_W'(y_eff) + SUM_W'(sub);
        result = (op == OP_PASS) ? a : sum[DATA_W-1:0];
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    // C is the raw adder carry, which for subtraction equals NOT borrow.
    always_comb begin
        flag_n = result[DATA_W-1];
        flag_z = (result == '0);
        flag_c = (op == OP_PASS) ? 1'b0 : sum[DATA_W];
        flag_v = (op == OP_PASS) ? 1'b0 :
                 ((x[DATA_W-1] == y_eff[DATA_W-1]) && (sum[DATA_W-1] != x[DATA_W-1]));
        flags  = {flag_n, flag_z, flag_c, flag_v};
    end
`endif

endmodule

// File: rtl/alu_seq_arbiter.sv
// Two-requester round-robin front end to a single shared ALU with an
// IDLE/EXEC/HOLD sequencer. rsp_flags exists only with ALU_SEQ_FLAGS_EN.
module alu_seq_arbiter
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
`ifdef ALU_SEQ_FLAGS_EN
    output logic [3:0]        rsp_flags,
`endif
    output logic [DATA_W-1:0] rsp_result
);

    state_e            state_q,  state_d;
    logic              rr_q,     rr_d;
    logic [1:0]        op_q,     op_d;
    logic [DATA_W-1:0] a_q,      a_d;
    logic [DATA_W-1:0] b_q,      b_d;
    logic              id_q,     id_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic              grant_valid;
    logic              grant_id;
    logic              accept;
    logic [1:0]        sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [DATA_W-1:0] core_result;

`ifdef ALU_SEQ_FLAGS_EN
    logic [3:0]        flags_q, flags_d;
    logic [3:0]        core_flags;
`endif

    // rr_q holds the last served id; on a tie the other requester wins.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = (req0_valid & req1_valid) ? ~rr_q : req1_valid;
        accept      = (state_q == ST_IDLE) & ~rst & grant_valid;
        req0_ready  = accept & ~grant_id;
        req1_ready  = accept &  grant_id;
        sel_op      = grant_id ? req1_op : req0_op;
        sel_a       = grant_id ? req1_a  : req0_a;
        sel_b       = grant_id ? req1_b  : req0_b;
    end

    alu_addsub_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
`ifdef ALU_SEQ_FLAGS_EN
        .flags  (core_flags),
`endif
        .result (core_result)
    );

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        rsp_id_d = rsp_id_q;
        result_d = result_q;
`ifdef ALU_SEQ_FLAGS_EN
        flags_d  = flags_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = sel_op;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    id_d    = grant_id;
                    rr_d    = grant_id;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = core_result;
                rsp_id_d = id_q;
`ifdef ALU_SEQ_FLAGS_EN
                flags_d  = core_flags;
`endif
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_q     <= 1'b1;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= 1'b0;
            rsp_id_q <= 1'b0;
            result_q <= '0;
`ifdef ALU_SEQ_FLAGS_EN
            flags_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            rsp_id_q <= rsp_id_d;
            result_q <= result_d;
`ifdef ALU_SEQ_FLAGS_EN
            flags_q  <= flags_d;
`endif
        end
    end

    assign rsp_valid  = (state_q == ST_HOLD);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = result_q;
`ifdef ALU_SEQ_FLAGS_EN
    assign rsp_flags  = flags_q;
`endif

endmodule

// File: tb/tb_alu_seq_arbiter.sv
// Self-checking bench for alu_seq_arbiter: vector table, scoreboard queue and
// directed sequences for hold, reset-in-flight and round-robin behaviour.
module tb_alu_seq_arbiter;

    localparam int DW = 32;
    localparam longint SMAX = 64'sh7FFFFFFF;
    localparam longint SMIN = -64'sh80000000;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [1:0]    req0_op, req1_op;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [DW-1:0] rsp_result;
`ifdef ALU_SEQ_FLAGS_EN
    logic [3:0]    rsp_flags;
`endif

    always #5 clk = ~clk;

    alu_seq_arbiter #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
`ifdef ALU_SEQ_FLAGS_EN
        .rsp_flags  (rsp_flags),
`endif
        .rsp_result (rsp_result)
    );

    typedef struct {
        logic          id;
        logic [1:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] res;
        logic [3:0]    flg;
    } vec_t;

    typedef struct {
        logic          id;
        logic [DW-1:0] res;
        logic [3:0]    flg;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];
    vec_t vecs[9];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic exp_t model(logic id, logic [1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
        exp_t        e;
        longint      sa, sb, s;
        logic [32:0] w;
        logic        c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin w = {1'b0, a} + {1'b0, b}; e.res = w[31:0]; c = w[32]; s = sa + sb; end
            2'b01: begin e.res = a - b; c = (a >= b); s = sa - sb; end
            2'b10: begin e.res = b - a; c = (b >= a); s = sb - sa; end
            default: begin e.res = a; c = 1'b0; s = sa; end
        endcase
        v = (op == 2'b11) ? 1'b0 : ((s > SMAX) || (s < SMIN));
        e.id  = id;
        e.flg = {e.res[31], (e.res == '0), c, v};
        return e;
    endfunction

    task automatic pop_check(string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            check({tag, "_unexpected_rsp"}, 64'd1, 64'd0);
        end else begin
            e = sbq.pop_front();
            $display("rsp %s: id=%0d result=%08h", tag, rsp_id, rsp_result);
            check({tag, "_id"}, 64'(rsp_id), 64'(e.id));
            check({tag, "_result"}, 64'(rsp_result), 64'(e.res));
`ifdef ALU_SEQ_FLAGS_EN
            check({tag, "_flags"}, 64'(rsp_flags), 64'(e.flg));
`endif
        end
    endtask

    task automatic drive_req(logic id, logic [1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    task automatic scramble_idle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 2'($urandom); req0_a = $urandom; req0_b = $urandom;
        req1_op = 2'($urandom); req1_a = $urandom; req1_b = $urandom;
    endtask

    // Issue one vector, check accept, 2-cycle latency, result and release.
    task automatic do_vec(vec_t v, string tag);
        int k;
        bit acc;
        acc = 1'b0;
        drive_req(v.id, v.op, v.a, v.b);
        #1;
        for (k = 0; k < 10; k++) begin
            if (v.id ? req1_ready : req0_ready) begin
                acc = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, "_accept"}, 64'(acc), 64'd1);
        if (acc) begin
            sbq.push_back('{v.id, v.res, v.flg});
            @(posedge clk); #1;
            scramble_idle();
            k = 0;
            while (!rsp_valid && k < 10) begin
                @(posedge clk); #1;
                k++;
            end
            check({tag, "_latency"}, 64'(k), 64'd1);
            if (rsp_valid) pop_check(tag);
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            check({tag, "_release"}, 64'(rsp_valid), 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        int   n_acc, n_rsp, cyc;
        bit   a0, a1, prev_acc;
        logic exp_ids [4];

        vecs[0] = '{1'b0, 2'b10, 32'd5,          32'd3,          32'hFFFFFFFE, 4'b1000};
        vecs[1] = '{1'b1, 2'b01, 32'd1,          32'd1,          32'h00000000, 4'b0110};
        vecs[2] = '{1'b0, 2'b10, 32'h7FFFFFFF,   32'h80000001,   32'h00000002, 4'b0011};
        vecs[3] = '{1'b1, 2'b00, 32'hFFFFFFFF,   32'h00000001,   32'h00000000, 4'b0110};
        vecs[4] = '{1'b0, 2'b00, 32'h7FFFFFFF,   32'h00000001,   32'h80000000, 4'b1001};
        vecs[5] = '{1'b1, 2'b11, 32'h12345678,   32'hFFFFFFFF,   32'h12345678, 4'b0000};
        vecs[6] = '{1'b0, 2'b01, 32'd3,          32'd5,          32'hFFFFFFFE, 4'b1000};
        vecs[7] = '{1'b1, 2'b01, 32'h80000000,   32'h00000001,   32'h7FFFFFFF, 4'b0011};
        vecs[8] = '{1'b0, 2'b11, 32'h00000000,   32'h00000009,   32'h00000000, 4'b0100};

        // Reset with both requesters valid: ready must stay low.
        rst = 1'b1; rsp_ready = 1'b0;
        drive_req(1'b0, 2'b00, 32'd1, 32'd2);
        drive_req(1'b1, 2'b00, 32'd3, 32'd4);
        for (k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
        end
        rst = 1'b0;
        scramble_idle();
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_rsp_result", 64'(rsp_result), 64'd0);
`ifdef ALU_SEQ_FLAGS_EN
        check("rst_rsp_flags", 64'(rsp_flags), 64'd0);
`endif

        for (int i = 0; i < 9; i++) begin
            $display("vec %0d: id=%0d op=%0d a=%08h b=%08h", i, vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
            do_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Response held for 5 cycles while both requesters keep asking.
        drive_req(1'b0, 2'b00, 32'd10, 32'd20);
        #1;
        check("hold_accept", 64'(req0_ready), 64'd1);
        sbq.push_back(model(1'b0, 2'b00, 32'd10, 32'd20));
        @(posedge clk); #1;
        drive_req(1'b0, 2'b01, 32'd9, 32'd4);
        drive_req(1'b1, 2'b11, 32'hAB, 32'd0);
        @(posedge clk); #1;
        check("hold_latency", 64'(rsp_valid), 64'd1);
        for (k = 0; k < 5; k++) begin
            $display("hold cycle %0d: rsp_valid=%0d result=%08h", k, rsp_valid, rsp_result);
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_result", 64'(rsp_result), 64'd30);
            check("hold_id", 64'(rsp_id), 64'd0);
            check("hold_ready", 64'({req0_ready, req1_ready}), 64'd0);
            @(posedge clk); #1;
        end
        if (rsp_valid) pop_check("hold");
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("hold_release", 64'(rsp_valid), 64'd0);
        check("hold_tie_grants_1", 64'({req1_ready, req0_ready}), 64'b10);
        scramble_idle();

        // Reset while the op is in EXEC: it must vanish, pointer back to 1.
        drive_req(1'b0, 2'b00, 32'd1, 32'd2);
        #1;
        check("rexec_accept", 64'(req0_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rexec_ready_in_rst", 64'({req0_ready, req1_ready}), 64'd0);
        rst = 1'b0;
        scramble_idle();
        #1;
        check("rexec_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rexec_rsp_result", 64'(rsp_result), 64'd0);
        check("rexec_rsp_id", 64'(rsp_id), 64'd0);
        for (k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("rexec_no_stale", 64'(rsp_valid), 64'd0);
        end
        drive_req(1'b0, 2'($urandom), $urandom, $urandom);
        drive_req(1'b1, 2'($urandom), $urandom, $urandom);
        #1;
        check("rexec_tie_grants_0", 64'({req1_ready, req0_ready}), 64'b01);

        // Round robin with both valid continuously; consumer always ready.
        exp_ids[0] = 1'b0; exp_ids[1] = 1'b1; exp_ids[2] = 1'b0; exp_ids[3] = 1'b1;
        rsp_ready = 1'b1;
        n_acc = 0; n_rsp = 0; cyc = 0; prev_acc = 1'b0;
        while (n_rsp < 4 && cyc < 60) begin
            a0 = req0_valid & req0_ready;
            a1 = req1_valid & req1_ready;
            check("rr_ready_busy", 64'((prev_acc || rsp_valid) && (req0_ready || req1_ready)), 64'd0);
            if (a0) sbq.push_back(model(1'b0, req0_op, req0_a, req0_b));
            if (a1) sbq.push_back(model(1'b1, req1_op, req1_a, req1_b));
            if (a0 | a1) n_acc++;
            if (rsp_valid) begin
                check("rr_id_seq", 64'(rsp_id), 64'(exp_ids[n_rsp]));
                pop_check($sformatf("rr%0d", n_rsp));
                n_rsp++;
            end
            prev_acc = a0 | a1;
            @(posedge clk); #1;
            if (a0) begin req0_op = 2'($urandom); req0_a = $urandom; req0_b = $urandom; end
            if (a1) begin req1_op = 2'($urandom); req1_a = $urandom; req1_b = $urandom; end
            if (n_acc >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            #1;
            cyc++;
        end
        check("rr_count", 64'(n_rsp), 64'd4);
        rsp_ready = 1'b0;
        check("sb_drained", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_arbiter.md
ALU_SEQ_ARBITER -- requirements
Module: alu_seq_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width in bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  in  1  requester n presents an operation.
REQ-005 req0_ready / req1_ready  out  1  arbiter accepts requester n's operation this cycle.
REQ-006 req0_op / req1_op  in  2  opcode: 00 ADD (a+b), 01 SUB (a-b), 10 RSB (b-a), 11 PASS (a).
REQ-007 req0_a, req0_b, req1_a, req1_b  in  DATA_W  operands.
REQ-008 rsp_valid  out  1  result available.
REQ-009 rsp_ready  in  1  consumer accepts result.
REQ-010 rsp_id  out  1  index of the requester that issued the result.
REQ-011 rsp_result  out  DATA_W  operation result, modulo 2^DATA_W.
REQ-012 rsp_flags  out  4  {N,Z,C,V}; present only with ALU_SEQ_FLAGS_EN.

Function
REQ-013 FSM states IDLE, EXEC, HOLD; reset state IDLE.
REQ-014 IDLE: at most one reqN_ready high, combinationally, to the granted valid requester; both low if no valid.
REQ-015 Grant: single valid requester wins; both valid -> requester not served last (round-robin pointer).
REQ-016 Handshake valid&ready in IDLE latches op, a, b, id; FSM -> EXEC; pointer updates to granted id.
REQ-017 EXEC: one cycle; result and flags computed from latched operands into output registers; FSM -> HOLD.
REQ-018 HOLD: rsp_valid=1; rsp_id/result/flags stable until rsp_valid&rsp_ready; then FSM -> IDLE, rsp_valid=0 next cycle.
REQ-019 Latency: request accepted cycle N -> rsp_valid high cycle N+2; max throughput one op per 3 cycles.
REQ-020 reqN_ready is low in EXEC and HOLD regardless of reqN_valid.
REQ-021 Requester may drop valid before ready without effect; operands are sampled only at handshake.
REQ-022 Arithmetic wraps mod 2^DATA_W: RSB 3,5 -> 0xFFFFFFFE; RSB a=0x7FFFFFFF,b=0x80000001 -> 0x00000002.
REQ-023 N = result MSB; Z = result==0; C = carry-out for ADD, NOT borrow for SUB/RSB, 0 for PASS.
REQ-024 V = signed overflow for ADD/SUB/RSB (operand order as executed), 0 for PASS.
REQ-025 rsp_ready high while rsp_valid low is ignored.

Reset
REQ-026 rst high: FSM -> IDLE; rsp_valid, rsp_id, rsp_result, rsp_flags, latched operands -> 0; RR pointer -> 1 (requester 0 wins first tie).
REQ-027 rst in EXEC or HOLD discards the in-flight op; no response is issued for it.
REQ-028 reqN_ready is 0 during any cycle rst is high.

Configuration
REQ-029 Macro ALU_SEQ_FLAGS_EN defined: rsp_flags port and flag registers present per REQ-023/024.
REQ-030 ALU_SEQ_FLAGS_EN undefined: no rsp_flags port, no flag logic; all other behaviour identical.

Structure
REQ-031 Package alu_seq_pkg holds DATA_W default, opcode constants (ADD/SUB/RSB/PASS), FSM state encoding.
REQ-032 Sub-module alu_addsub_core: combinational, inputs op/a/b, outputs result and {N,Z,C,V}; one instance.
REQ-033 Arbiter, FSM and output registers live in alu_seq_arbiter.

Verification
REQ-034 Reset then req0 RSB a=5,b=3 -> rsp_valid 2 cycles after accept, result 0xFFFFFFFE, id 0, flags N=1 Z=0 C=0 V=0.
REQ-035 req1 SUB a=1,b=1 -> result 0x00000000, id 1, Z=1 C=1 N=0 V=0.
REQ-036 Both valid continuously, 4 ops -> rsp_id sequence 0,1,0,1; req ready never high in EXEC/HOLD.
REQ-037 req0 RSB a=0x7FFFFFFF,b=0x80000001 -> result 0x00000002, V=1; ADD 0xFFFFFFFF+1 -> 0, C=1 Z=1.
REQ-038 rsp_ready held low 5 cycles in HOLD -> result/id stable, no new accept; rsp_ready high -> IDLE next cycle.
REQ-039 rst asserted in EXEC -> next cycle rsp_valid=0, outputs 0, no stale response; next tie grants requester 0.
